// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared CPU definitions used by the instruction/data memory arbiter:
//   - arb_state_e      : tracks which requester owns the read in flight
//   - MAX_DSTREAK_DEF  : default bound on consecutive data grants while a
//                        fetch is waiting
//   - streak_w()       : width needed to hold a streak count 0..max
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int MAX_DSTREAK_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_PEND = 2'd1,
    ST_D_PEND  = 2'd2
  } arb_state_e;

  function automatic int streak_w(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// -----------------------------------------------------------------------------
// mem_arb_prio
// Purely combinational grant decision between the fetch and data ports.
// Data wins by default; fetch wins once the data streak has reached MAX.
// Ports:
//   if_req    in   fetch request (already qualified by reset)
//   data_req  in   data read or write request (already qualified by reset)
//   streak    in   consecutive data grants issued while fetch was waiting
//   grant_if  out  fetch granted this cycle
//   grant_d   out  data granted this cycle
// -----------------------------------------------------------------------------
module mem_arb_prio #(
  parameter int MAX = 4,
  parameter int SW  = 3
) (
  input  logic          if_req,
  input  logic          data_req,
  input  logic [SW-1:0] streak,
  output logic          grant_if,
  output logic          grant_d
);

  logic w_starved;

  assign w_starved = if_req && (streak == SW'(MAX));

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (data_req && !w_starved) begin
      grant_d = 1'b1;
    end else if (if_req) begin
      grant_if = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between instruction fetch and data accesses.
// One grant per cycle at most; the grant drives the memory strobes in the same
// cycle. Reads return one cycle later and are steered to the owner's port.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   if_req/if_addr               fetch request and PC
//   if_gnt/if_valid/if_rdata     fetch accept, return valid, instruction
//   d_rd/d_wr/d_addr/d_wdata     data read/write request, address, store data
//   d_gnt/d_valid/d_rdata        data accept, load valid, load data
//   mem_rd/mem_wr/mem_addr/
//   mem_wdata/mem_rdata          single-port memory interface
//   stall_if/stall_mem           requester pending but not granted
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam int SW = streak_w(MAX_DSTREAK);

  logic          w_if_req;
  logic          w_d_req;
  logic          w_d_write;
  logic          w_if_gnt;
  logic          w_d_gnt;
  logic [SW-1:0] r_streak;
  arb_state_e    r_state;
  arb_state_e    w_state_nxt;

  // Requests are masked during reset so grants, strobes and stalls stay low.
  assign w_if_req  = if_req & ~reset;
  assign w_d_req   = (d_rd | d_wr) & ~reset;
  // Read and write together is a write; the read half is dropped.
  assign w_d_write = d_wr;

  mem_arb_prio #(
    .MAX (MAX_DSTREAK),
    .SW  (SW)
  ) u_prio (
    .if_req   (w_if_req),
    .data_req (w_d_req),
    .streak   (r_streak),
    .grant_if (w_if_gnt),
    .grant_d  (w_d_gnt)
  );

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign stall_if  = w_if_req & ~w_if_gnt;
  assign stall_mem = w_d_req & ~w_d_gnt;

  // Memory strobes follow the grant combinationally; idle drives all zeros.
  assign mem_rd    = w_if_gnt | (w_d_gnt & ~w_d_write);
  assign mem_wr    = w_d_gnt & w_d_write;
  assign mem_addr  = w_if_gnt ? if_addr : (w_d_gnt ? d_addr : '0);
  assign mem_wdata = (w_d_gnt && w_d_write) ? d_wdata : '0;

  // Streak counts data grants only while a fetch is actually waiting.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_if_gnt || !if_req) begin
      r_streak <= '0;
    end else if (w_d_gnt && (r_streak != SW'(MAX_DSTREAK))) begin
      r_streak <= r_streak + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = ST_IDLE;
    if_valid    = 1'b0;
    if_rdata    = '0;
    d_valid     = 1'b0;
    d_rdata     = '0;

    // A response whose cycle coincides with reset is discarded.
    if (!reset) begin
      case (r_state)
        ST_IF_PEND: begin
          if_valid = 1'b1;
          if_rdata = mem_rdata;
        end
        ST_D_PEND: begin
          d_valid = 1'b1;
          d_rdata = mem_rdata;
        end
        default: ;
      endcase
    end

    // A new read may be granted in the same cycle a response returns.
    if (w_if_gnt) begin
      w_state_nxt = ST_IF_PEND;
    end else if (w_d_gnt && !w_d_write) begin
      w_state_nxt = ST_D_PEND;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small word-addressed memory model.
// Memory word i (address i*4) is preloaded with 32'hC0DE_0000 | i.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  logic [31:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  mem_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory: write in grant cycle, read data one cycle after mem_rd.
  always @(posedge clock) begin
    if (mem_wr) mem[mem_addr[11:2]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_rd    = dr;
    d_wr    = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic idle();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample point: falling edge, well away from the active edge.
  task automatic sample();
    @(negedge clock);
  endtask

  logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic exp_f [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem_rdata = 32'h0;

    // ---- Reset with requests asserted: everything must stay quiet ----
    reset = 1'b1;
    set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, 32'h0);
    tick();
    tick();
    sample();
    check("rst_if_gnt",    32'(if_gnt),    32'h0);
    check("rst_d_gnt",     32'(d_gnt),     32'h0);
    check("rst_mem_rd",    32'(mem_rd),    32'h0);
    check("rst_mem_addr",  mem_addr,       32'h0);
    check("rst_stall_if",  32'(stall_if),  32'h0);
    check("rst_stall_mem", 32'(stall_mem), 32'h0);
    check("rst_if_valid",  32'(if_valid),  32'h0);
    check("rst_d_rdata",   d_rdata,        32'h0);
    check("rst_state",     32'(dut.r_state), 32'(ST_IDLE));
    check("rst_streak",    32'(dut.r_streak), 32'h0);
    tick();
    reset = 1'b0;
    idle();

    // ---- Idle cycle ----
    sample();
    check("idle_mem_rd",    32'(mem_rd), 32'h0);
    check("idle_mem_wr",    32'(mem_wr), 32'h0);
    check("idle_mem_addr",  mem_addr,    32'h0);
    check("idle_mem_wdata", mem_wdata,   32'h0);
    tick();

    // ---- Fetch only at 0x10 ----
    set_in(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("f_if_gnt",   32'(if_gnt),   32'h1);
    check("f_mem_rd",   32'(mem_rd),   32'h1);
    check("f_mem_addr", mem_addr,      32'h10);
    check("f_stall_if", 32'(stall_if), 32'h0);
    tick();
    idle();
    sample();
    check("f_if_valid", 32'(if_valid), 32'h1);
    check("f_if_rdata", if_rdata,      32'hC0DE_0004);
    check("f_d_valid",  32'(d_valid),  32'h0);
    tick();

    // ---- Fetch and data read collide: data wins, fetch follows ----
    set_in(1'b1, 32'h14, 1'b1, 1'b0, 32'h200, 32'h0);
    sample();
    check("c_d_gnt",    32'(d_gnt),    32'h1);
    check("c_if_gnt",   32'(if_gnt),   32'h0);
    check("c_stall_if", 32'(stall_if), 32'h1);
    check("c_mem_addr", mem_addr,      32'h200);
    tick();
    set_in(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("c_d_valid",   32'(d_valid), 32'h1);
    check("c_d_rdata",   d_rdata,      32'hC0DE_0080);
    check("c_if_gnt2",   32'(if_gnt),  32'h1);
    check("c_mem_addr2", mem_addr,     32'h14);
    tick();
    idle();
    sample();
    check("c_if_valid", 32'(if_valid), 32'h1);
    check("c_if_rdata", if_rdata,      32'hC0DE_0005);
    check("c_d_valid2", 32'(d_valid),  32'h0);
    tick();

    // ---- Streak: data write held 6 cycles with fetch pending ----
    for (int c = 0; c < 6; c++) begin
      set_in(1'b1, (c < 5) ? 32'h18 : 32'h1C, 1'b0, 1'b1, 32'h300, 32'hDEAD_BEEF);
      sample();
      check($sformatf("s_d_gnt_c%0d", c + 1),  32'(d_gnt),  32'(exp_d[c]));
      check($sformatf("s_if_gnt_c%0d", c + 1), 32'(if_gnt), 32'(exp_f[c]));
      if (c == 0) begin
        check("s_mem_wr",    32'(mem_wr), 32'h1);
        check("s_mem_wdata", mem_wdata,   32'hDEAD_BEEF);
      end
      if (c == 4) begin
        check("s_streak_sat", 32'(dut.r_streak), 32'd4);
        check("s_stall_mem",  32'(stall_mem),    32'h1);
      end
      if (c == 5) begin
        check("s_if_valid", 32'(if_valid), 32'h1);
        check("s_if_rdata", if_rdata,      32'hC0DE_0006);
      end
      tick();
    end
    idle();
    sample();
    check("s_mem300", mem[192], 32'hDEAD_BEEF);
    check("s_no_dvalid", 32'(d_valid), 32'h0);
    tick();

    // ---- Alternating fetch / data reads, one per cycle ----
    set_in(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("a1_if_gnt", 32'(if_gnt), 32'h1);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h204, 32'h0);
    sample();
    check("a2_d_gnt",    32'(d_gnt),    32'h1);
    check("a2_if_valid", 32'(if_valid), 32'h1);
    check("a2_if_rdata", if_rdata,      32'hC0DE_0008);
    tick();
    set_in(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("a3_if_gnt",   32'(if_gnt),   32'h1);
    check("a3_d_valid",  32'(d_valid),  32'h1);
    check("a3_if_valid", 32'(if_valid), 32'h0);
    check("a3_d_rdata",  d_rdata,       32'hC0DE_0081);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h208, 32'h0);
    sample();
    check("a4_d_gnt",    32'(d_gnt),    32'h1);
    check("a4_if_valid", 32'(if_valid), 32'h1);
    check("a4_if_rdata", if_rdata,      32'hC0DE_0009);
    tick();
    idle();
    sample();
    check("a5_d_valid", 32'(d_valid), 32'h1);
    check("a5_d_rdata", d_rdata,      32'hC0DE_0082);
    check("a5_mem_rd",  32'(mem_rd),  32'h0);
    tick();

    // ---- Read and write together at 0x40: write only ----
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
    sample();
    check("rw_d_gnt",  32'(d_gnt),  32'h1);
    check("rw_mem_wr", 32'(mem_wr), 32'h1);
    check("rw_mem_rd", 32'(mem_rd), 32'h0);
    tick();
    idle();
    sample();
    check("rw_no_dvalid", 32'(d_valid), 32'h0);
    check("rw_mem40",     mem[16],      32'h1234_5678);
    tick();

    // ---- Reset in the cycle after a data read grant ----
    set_in(1'b1, 32'h30, 1'b1, 1'b0, 32'h200, 32'h0);
    sample();
    check("r_d_gnt", 32'(d_gnt), 32'h1);
    tick();
    reset = 1'b1;
    idle();
    sample();
    check("r_d_valid_in_rst", 32'(d_valid), 32'h0);
    check("r_d_rdata_in_rst", d_rdata,      32'h0);
    tick();
    reset = 1'b0;
    sample();
    check("r_state",        32'(dut.r_state),  32'(ST_IDLE));
    check("r_streak",       32'(dut.r_streak), 32'h0);
    check("r_d_valid_post", 32'(d_valid),      32'h0);
    check("r_if_valid_post", 32'(if_valid),    32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
